ped_request_conditioner: RTL and testbench

Two-channel pedestrian push-button front end. It sits directly upstream of the two-way intersection controller. Each raw active-low crosswalk button is synchronized, debounced and edge-detected, then latched as a pending request. The request drives the controller's active-low crosswalk inputs until the controller reports that the crossing was served, after which a lockout window suppresses immediate re-requests.

---
 rtl/ped_request_conditioner.sv | 147 ++++++++++++++
 tb/tb_ped_request_conditioner.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ped_request_conditioner.sv
// Two-channel pedestrian button front end: sync, debounce, falling-edge detect,
// then a request/serve/lockout handshake toward the intersection controller.
module ped_request_conditioner #(
  parameter int DB_CYCLES      = 16,
  parameter int LOCKOUT_CYCLES = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic button_n_0,
  input  logic button_n_1,
  input  logic svc_0,
  input  logic svc_1,
  output logic crosswalk_0,
  output logic crosswalk_1,
  output logic press_0,
  output logic press_1,
  output logic busy_0,
  output logic busy_1
);

  localparam int DBW = ($clog2(DB_CYCLES + 1) < 1) ? 1 : $clog2(DB_CYCLES + 1);
  localparam int LKW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
  localparam logic [LKW-1:0] LK_LOAD = LKW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_SERVING = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  logic [1:0] w_button_n;
  logic [1:0] w_svc;
  logic [1:0] w_crosswalk_n;
  logic [1:0] w_press_out;
  logic [1:0] w_busy;

  assign w_button_n = {button_n_1, button_n_0};
  assign w_svc      = {svc_1, svc_0};

  assign crosswalk_0 = w_crosswalk_n[0];
  assign crosswalk_1 = w_crosswalk_n[1];
  assign press_0     = w_press_out[0];
  assign press_1     = w_press_out[1];
  assign busy_0      = w_busy[0];
  assign busy_1      = w_busy[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      logic           r_sync1;
      logic           r_sync2;
      logic           r_db;
      logic           r_db_d;
      logic [DBW-1:0] r_db_cnt;
      logic [LKW-1:0] r_lock_cnt;
      logic [LKW-1:0] w_lock_cnt_next;
      state_t         r_state;
      state_t         w_state_next;
      logic           w_press;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_sync1 <= 1'b1;
          r_sync2 <= 1'b1;
        end else begin
          r_sync1 <= w_button_n[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Any sample agreeing with the current level restarts qualification.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_db     <= 1'b1;
          r_db_d   <= 1'b1;
          r_db_cnt <= '0;
        end else begin
          r_db_d <= r_db;
          if (r_sync2 != r_db) begin
            if (r_db_cnt == DB_LAST) begin
              r_db     <= r_sync2;
              r_db_cnt <= '0;
            end else begin
              r_db_cnt <= r_db_cnt + DBW'(1);
            end
          end else begin
            r_db_cnt <= '0;
          end
        end
      end

      assign w_press = r_db_d & ~r_db;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_state    <= ST_IDLE;
          r_lock_cnt <= '0;
        end else begin
          r_state    <= w_state_next;
          r_lock_cnt <= w_lock_cnt_next;
        end
      end

      always_comb begin
        w_state_next    = r_state;
        w_lock_cnt_next = r_lock_cnt;
        case (r_state)
          ST_IDLE: begin
            if (w_press) w_state_next = ST_PENDING;
          end
          ST_PENDING: begin
            if (w_svc[gi]) w_state_next = ST_SERVING;
          end
          ST_SERVING: begin
            if (!w_svc[gi]) begin
              if (LOCKOUT_CYCLES == 0) begin
                w_state_next = ST_IDLE;
              end else begin
                w_state_next    = ST_LOCKOUT;
                w_lock_cnt_next = LK_LOAD;
              end
            end
          end
          ST_LOCKOUT: begin
            if (r_lock_cnt <= LKW'(1)) begin
              w_state_next    = ST_IDLE;
              w_lock_cnt_next = '0;
            end else begin
              w_lock_cnt_next = r_lock_cnt - LKW'(1);
            end
          end
          default: begin
            w_state_next    = ST_IDLE;
            w_lock_cnt_next = '0;
          end
        endcase
      end

      // The debug pulse only reports presses the FSM actually accepts.
      assign w_crosswalk_n[gi] = (r_state != ST_PENDING);
      assign w_busy[gi]        = (r_state == ST_SERVING) || (r_state == ST_LOCKOUT);
      assign w_press_out[gi]   = w_press & (r_state == ST_IDLE);
    end
  endgenerate

endmodule

// File: tb/tb_ped_request_conditioner.sv
// Self-checking bench: directed handshake scenarios plus randomized buttons/svc,
// compared every cycle against a run-length / deadline behavioural model.
module tb_ped_request_conditioner;
  localparam int DB = 16;
  localparam int LK = 32;
  localparam int M_IDLE = 0, M_PEND = 1, M_SERV = 2, M_LOCK = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic button_n_0 = 1'b1, button_n_1 = 1'b1;
  logic svc_0 = 1'b0, svc_1 = 1'b0;
  logic crosswalk_0, crosswalk_1, press_0, press_1, busy_0, busy_1;

  always #5 clk = ~clk;

  ped_request_conditioner #(.DB_CYCLES(DB), .LOCKOUT_CYCLES(LK)) dut (
    .clk(clk), .reset_n(reset_n),
    .button_n_0(button_n_0), .button_n_1(button_n_1),
    .svc_0(svc_0), .svc_1(svc_1),
    .crosswalk_0(crosswalk_0), .crosswalk_1(crosswalk_1),
    .press_0(press_0), .press_1(press_1),
    .busy_0(busy_0), .busy_1(busy_1)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: button sample seen by the debouncer is the one taken two edges ago;
  // the level flips after DB consecutive disagreeing samples; lockout is a deadline.
  bit     m_s1[2], m_s2[2], m_db[2], m_fell[2];
  int     m_run[2], m_mode[2];
  longint m_until[2];
  longint cyc = 0;

  function automatic void model_reset();
    for (int c = 0; c < 2; c++) begin
      m_s1[c] = 1; m_s2[c] = 1; m_db[c] = 1; m_fell[c] = 0;
      m_run[c] = 0; m_mode[c] = M_IDLE; m_until[c] = 0;
    end
  endfunction

  function automatic void model_edge();
    bit btn, svc, lvl;
    for (int c = 0; c < 2; c++) begin
      btn = (c == 0) ? button_n_0 : button_n_1;
      svc = (c == 0) ? svc_0 : svc_1;
      case (m_mode[c])
        M_IDLE: if (m_fell[c]) m_mode[c] = M_PEND;
        M_PEND: if (svc) m_mode[c] = M_SERV;
        M_SERV: if (!svc) begin
          if (LK == 0) m_mode[c] = M_IDLE;
          else begin m_mode[c] = M_LOCK; m_until[c] = cyc + LK; end
        end
        default: if (cyc == m_until[c]) m_mode[c] = M_IDLE;
      endcase
      lvl = m_s2[c];
      m_fell[c] = 0;
      if (lvl != m_db[c]) begin
        m_run[c]++;
        if (m_run[c] == DB) begin
          m_fell[c] = (lvl == 0);
          m_db[c] = lvl;
          m_run[c] = 0;
        end
      end else begin
        m_run[c] = 0;
      end
      m_s2[c] = m_s1[c];
      m_s1[c] = btn;
    end
  endfunction

  task automatic compare_all();
    check_eq("cw0",   crosswalk_0, (m_mode[0] == M_PEND) ? 0 : 1);
    check_eq("cw1",   crosswalk_1, (m_mode[1] == M_PEND) ? 0 : 1);
    check_eq("pr0",   press_0, (m_fell[0] && m_mode[0] == M_IDLE) ? 1 : 0);
    check_eq("pr1",   press_1, (m_fell[1] && m_mode[1] == M_IDLE) ? 1 : 0);
    check_eq("busy0", busy_0, (m_mode[0] == M_SERV || m_mode[0] == M_LOCK) ? 1 : 0);
    check_eq("busy1", busy_1, (m_mode[1] == M_SERV || m_mode[1] == M_LOCK) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) begin
      model_edge();
      cyc++;
    end
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cw0"}, crosswalk_0, 1);
    check_eq({tag, "_cw1"}, crosswalk_1, 1);
    check_eq({tag, "_pr0"}, press_0, 0);
    check_eq({tag, "_pr1"}, press_1, 0);
    check_eq({tag, "_busy0"}, busy_0, 0);
    check_eq({tag, "_busy1"}, busy_1, 0);
  endtask

  // Ticks until crosswalk of channel ch falls; -1 if it never does.
  task automatic wait_fall(input int ch, output int n);
    n = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (((ch == 0) ? crosswalk_0 : crosswalk_1) == 1'b0) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic serve_ch0(input int hold);
    svc_0 = 1'b1;
    repeat (hold) tick();
    svc_0 = 1'b0;
    repeat (LK + 4) tick();
  endtask

  initial begin
    int n, busy_cnt, pcnt;
    int hold_b[2], hold_s[2];

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    repeat (4) tick();

    // Clean press on ch0.
    button_n_0 = 1'b0;
    wait_fall(0, n);
    check_eq("lat_clean", n, DB + 2);
    check_eq("ch1_idle_cw", crosswalk_1, 1);
    button_n_0 = 1'b1;
    repeat (DB + 6) tick();

    // Handshake, with a second press started right as service ends.
    busy_cnt = 0;
    svc_0 = 1'b1;
    repeat (10) begin tick(); if (busy_0) busy_cnt++; end
    svc_0 = 1'b0;
    button_n_0 = 1'b0;
    pcnt = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (press_0) pcnt++;
      if (!busy_0) break;
      busy_cnt++;
    end
    check_eq("busy_len", busy_cnt, 10 + LK);
    check_eq("lock_press", pcnt, 0);
    repeat (30) tick();
    check_eq("held_norereq", crosswalk_0, 1);
    button_n_0 = 1'b1;
    repeat (DB + 6) tick();
    button_n_0 = 1'b0;
    wait_fall(0, n);
    check_eq("lat_after_lock", n, DB + 2);
    button_n_0 = 1'b1;
    serve_ch0(3);

    // Bounce: toggle every 5 cycles for 40 cycles, then hold low.
    pcnt = 0;
    for (int s = 0; s < 8; s++) begin
      button_n_0 = s[0];
      repeat (5) begin tick(); if (press_0) pcnt++; end
    end
    check_eq("bounce_press", pcnt, 0);
    button_n_0 = 1'b0;
    wait_fall(0, n);
    check_eq("lat_bounce", n, DB + 2);
    button_n_0 = 1'b1;
    serve_ch0(2);

    // Both channels on the same edge, then serve ch0 only.
    button_n_0 = 1'b0;
    button_n_1 = 1'b0;
    n = -1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!crosswalk_0 || !crosswalk_1) begin n = i; break; end
    end
    check_eq("lat_both", n, DB + 2);
    check_eq("both_cw0", crosswalk_0, 0);
    check_eq("both_cw1", crosswalk_1, 0);
    button_n_0 = 1'b1;
    button_n_1 = 1'b1;
    serve_ch0(4);
    check_eq("cw1_still_low", crosswalk_1, 0);

    // Reset mid-PENDING on ch1.
    reset_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midrst");
    repeat (3) tick();
    reset_n = 1'b1;
    svc_1 = 1'b1;
    repeat (5) tick();
    svc_1 = 1'b0;
    check_eq("post_rst_busy1", busy_1, 0);
    repeat (5) tick();

    // Randomized buttons and svc levels with varied hold times.
    hold_b = '{0, 0};
    hold_s = '{0, 0};
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold_b[c] == 0) begin
          hold_b[c] = $urandom_range(1, 30);
          if (c == 0) button_n_0 = 1'($urandom_range(0, 1));
          else        button_n_1 = 1'($urandom_range(0, 1));
        end
        if (hold_s[c] == 0) begin
          hold_s[c] = $urandom_range(1, 60);
          if (c == 0) svc_0 = 1'($urandom_range(0, 1));
          else        svc_1 = 1'($urandom_range(0, 1));
        end
        hold_b[c]--;
        hold_s[c]--;
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
